pipe_field: RTL

- Parametrised successor to the single-pipe register.
- Manages NUM_PIPES scrolling pipe obstacles on the 160x120 VGA playfield.
- Holds a FIFO of pending gap-top y values: each value is clamped to a legal range on entry and consumed when a pipe spawns.
- Scrolls pipes left on a single-cycle game_tick enable in the CLOCK_50 domain, retires them at x=0, and pulses score_pulse when a pipe passes the bird column.
- Feeds the pipe drawer and collision logic.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/y_fifo.sv | 70 +++++++
 rtl/pipe_field.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared playfield geometry and pipe defaults for the scrolling pipe obstacles.
// Holds only constants and a clamp helper; no timing or flow control of its own.
package pipe_pkg;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int GAP_H     = 20;
    localparam int Y_MIN     = 5;
    localparam int Y_MAX     = 95;
    localparam int DEFAULT_Y = 50;
    localparam int BIRD_X    = 40;

    function automatic int clamp_y(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction
endpackage

// File: rtl/y_fifo.sv
// Synchronous FIFO of gap-top y values; count/full registered, head visible the cycle after a push.
// No backpressure: a push while full is dropped unless a pop is accepted in the same cycle.
module y_fifo #(
    parameter int QDEPTH = 8,
    parameter int W      = pipe_pkg::Y_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            head,
    output logic [$clog2(QDEPTH):0] count,
    output logic                    full,
    output logic                    empty
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [W-1:0]  mem_q [QDEPTH];
    logic [W-1:0]  mem_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full_q || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        full_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = (count_q == '0);
endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe slots with spawn spacing, retirement at x=0 and bird-column scoring; outputs registered, 1-cycle latency.
// No backpressure: deferred spawns wait for a free slot, y pushes are dropped when the queue is full.
module pipe_field #(
    parameter int NUM_PIPES    = 3,
    parameter int QDEPTH       = 8,
    parameter int X_W          = pipe_pkg::X_W,
    parameter int Y_W          = pipe_pkg::Y_W,
    parameter int SCREEN_W     = pipe_pkg::SCREEN_W,
    parameter int PIPE_SPACING = 54,
    parameter int Y_MIN        = pipe_pkg::Y_MIN,
    parameter int Y_MAX        = pipe_pkg::Y_MAX,
    parameter int DEFAULT_Y    = pipe_pkg::DEFAULT_Y,
    parameter int BIRD_X       = pipe_pkg::BIRD_X
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       game_tick,
    input  logic                       rand_valid,
    input  logic [Y_W-1:0]             rand_in,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x,
    output logic [NUM_PIPES*Y_W-1:0]   pipe_y,
    output logic [NUM_PIPES-1:0]       pipe_active,
    output logic                       score_pulse,
    output logic [$clog2(QDEPTH):0]    q_count,
    output logic                       q_full
);
    import pipe_pkg::*;

    localparam int CNT_W = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
    localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(PIPE_SPACING - 1);
    localparam logic [X_W-1:0]   SPAWN_X    = X_W'(SCREEN_W);
    localparam logic [X_W-1:0]   SCORE_X    = X_W'(BIRD_X);
    localparam logic [Y_W-1:0]   DEF_Y      = Y_W'(DEFAULT_Y);

    logic                 tick_en;
    logic [NUM_PIPES-1:0] slot_act, free, spawn_sel, slot_score;
    logic [CNT_W-1:0]     spawn_cnt_q, spawn_cnt_d;
    logic                 score_q, score_d;
    logic                 spawn, fifo_pop, fifo_empty;
    logic [Y_W-1:0]       push_dat, fifo_head, spawn_y;

    assign tick_en = game_tick && enable;
    assign free    = ~slot_act;
    // Isolates the lowest set bit: the lowest-index free slot as a one-hot select.
    assign spawn_sel = free & ~(free - NUM_PIPES'(1));

    always_comb begin
        spawn    = tick_en && (spawn_cnt_q == SPAWN_LAST) && (|free);
        fifo_pop = spawn && !fifo_empty;
        spawn_y  = fifo_empty ? DEF_Y : fifo_head;
        push_dat = Y_W'(clamp_y(int'(rand_in), Y_MIN, Y_MAX));
        spawn_cnt_d = spawn_cnt_q;
        if (spawn) begin
            spawn_cnt_d = '0;
        end else if (tick_en && (spawn_cnt_q != SPAWN_LAST)) begin
            spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
        end
        score_d = tick_en && (|slot_score);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            spawn_cnt_q <= SPAWN_LAST;
            score_q     <= 1'b0;
        end else begin
            spawn_cnt_q <= spawn_cnt_d;
            score_q     <= score_d;
        end
    end

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
        logic [X_W-1:0] x_q, x_d;
        logic [Y_W-1:0] y_q, y_d;
        logic           act_q, act_d;

        always_comb begin
            x_d   = x_q;
            y_d   = y_q;
            act_d = act_q;
            if (tick_en) begin
                if (act_q) begin
                    if (x_q != '0) begin
                        x_d = x_q - X_W'(1);
                    end else begin
                        act_d = 1'b0;
                    end
                end
                // A spawning slot was inactive before the tick, so it never collides with the move above.
                if (spawn && spawn_sel[i]) begin
                    act_d = 1'b1;
                    x_d   = SPAWN_X;
                    y_d   = spawn_y;
                end
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                x_q   <= SPAWN_X;
                y_q   <= DEF_Y;
                act_q <= 1'b0;
            end else begin
                x_q   <= x_d;
                y_q   <= y_d;
                act_q <= act_d;
            end
        end

        assign slot_act[i]            = act_q;
        assign slot_score[i]          = act_q && (x_q == SCORE_X);
        assign pipe_x[i*X_W +: X_W]   = x_q;
        assign pipe_y[i*Y_W +: Y_W]   = y_q;
    end

    y_fifo #(
        .QDEPTH (QDEPTH),
        .W      (Y_W)
    ) u_y_fifo (
        .clk      (CLOCK_50),
        .reset    (reset),
        .push     (rand_valid),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (fifo_empty)
    );

    assign pipe_active = slot_act;
    assign score_pulse = score_q;
endmodule
